pcm_fifo: RTL and testbench

Parametrised synchronous first-word-fall-through FIFO for the PCM microphone capture path, buffering samples between the PDM/PCM decimator and the audio consumer (DAC/UART/RAM writer). It generalises the earlier fixed 8x8 buffer: configurable width and depth, an exact fill-level output, programmable almost-full/almost-empty thresholds, and defined behaviour for every combination of read, write, full and empty. An optional sticky overflow/underflow error block can be compiled in.

---
 rtl/pcm_fifo_if.sv | 49 ++++
 rtl/pcm_fifo.sv | 128 ++++++++++++
 tb/tb_pcm_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pcm_fifo_if.sv
// pcm_fifo_if: sample-path bundle between the PCM decimator, pcm_fifo and the
// audio consumer. Optional error signals exist only when PCM_FIFO_ERR_EN is defined.
interface pcm_fifo_if #(
  parameter int unsigned ABITS = 3,
  parameter int unsigned DBITS = 8
);

  logic             wr;
  logic             rd;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             empty;
  logic             full;
  logic [ABITS:0]   level;
  logic             almost_full;
  logic             almost_empty;
`ifdef PCM_FIFO_ERR_EN
  logic             err_clr;
  logic             overflow;
  logic             underflow;
`endif

`ifdef PCM_FIFO_ERR_EN
  // Producer/consumer side.
  modport master (
    output wr, rd, din, err_clr,
    input  dout, empty, full, level, almost_full, almost_empty, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  wr, rd, din, err_clr,
    output dout, empty, full, level, almost_full, almost_empty, overflow, underflow
  );
`else
  // Producer/consumer side.
  modport master (
    output wr, rd, din,
    input  dout, empty, full, level, almost_full, almost_empty
  );

  // FIFO side.
  modport slave (
    input  wr, rd, din,
    output dout, empty, full, level, almost_full, almost_empty
  );
`endif

endinterface

// File: rtl/pcm_fifo.sv
// pcm_fifo: first-word-fall-through sample FIFO for the PCM capture path.
// Depth is 2**ABITS words of DBITS bits. Flags are registered and computed from
// the next level, so they never lag the level output.
// Optional feature macro: PCM_FIFO_ERR_EN adds sticky overflow/underflow flags
// with an err_clr input. ABITS/DBITS must match the connected pcm_fifo_if.
module pcm_fifo #(
  parameter int unsigned ABITS    = 3,
  parameter int unsigned DBITS    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic      clock,
  input  logic      reset,
  pcm_fifo_if.slave bus
);

  localparam int unsigned Depth    = 1 << ABITS;
  localparam logic [ABITS:0]   DepthLvl = (ABITS+1)'(Depth);
  localparam logic [ABITS:0]   AfLvl    = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0]   AeLvl    = (ABITS+1)'(AE_LEVEL);
  localparam logic [ABITS:0]   LvlOne   = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] PtrOne   = ABITS'(1);

  logic [DBITS-1:0] mem_q [Depth];

  logic [ABITS-1:0] wp_q, wp_d;
  logic [ABITS-1:0] rp_q, rp_d;
  logic [ABITS:0]   level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;

  logic wr_acc;
  logic rd_acc;

  // A write is accepted when space exists or a simultaneous read frees a slot;
  // a read is accepted only when data is present (no empty bypass).
  always_comb begin
    wr_acc = bus.wr && (!full_q || bus.rd);
    rd_acc = bus.rd && !empty_q;
  end

  // Next pointer/level values and flags derived from the next level.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (wr_acc) begin
      wp_d = wp_q + PtrOne;
    end
    if (rd_acc) begin
      rp_d = rp_q + PtrOne;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == DepthLvl);
    af_d    = (level_d >= AfLvl);
    ae_d    = (level_d <= AeLvl);
  end

  // Pointer, level and flag registers; reset discards all stored data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  // Sample storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wp_q] <= bus.din;
    end
  end

  // Fall-through head of queue; don't-care while empty.
  assign bus.dout         = mem_q[rp_q];
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.level        = level_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

`ifdef PCM_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags; a clear on the same edge beats a new set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.err_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr && full_q && !bus.rd) begin
        ovf_q <= 1'b1;
      end
      if (bus.rd && empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_pcm_fifo.sv
// tb_pcm_fifo: directed table-driven bench for pcm_fifo (ABITS=3, DBITS=8),
// plus hand-written pointer-wrap streaming and mid-stream reset sequences.
module tb_pcm_fifo;

  logic clock;
  logic reset;

  pcm_fifo_if #(.ABITS(3), .DBITS(8)) bus ();

  pcm_fifo #(
    .ABITS   (3),
    .DBITS   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic       chk_dout;
    logic [7:0] dout;
    logic [3:0] level;
    logic       empty;
    logic       full;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [7:0] din,
                     input logic chk_dout, input logic [7:0] dout, input logic [3:0] level,
                     input logic empty, input logic full, input logic af, input logic ae,
                     input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.chk_dout = chk_dout; v.dout = dout; v.level = level;
    v.empty = empty; v.full = full; v.af = af; v.ae = ae;
    v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
    bus.wr  = wr;
    bus.rd  = rd;
    bus.din = din;
`ifdef PCM_FIFO_ERR_EN
    bus.err_clr = clr;
`else
    if (clr) begin
      // err_clr does not exist without the error block.
    end
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".level"}, 32'(bus.level), 32'd0);
    chk({tag, ".empty"}, 32'(bus.empty), 32'd1);
    chk({tag, ".full"}, 32'(bus.full), 32'd0);
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'd1);
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'd0);
`ifdef PCM_FIFO_ERR_EN
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    int         wcount;
    int         popped;
    logic       wr_now, rd_now, wacc, racc;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    // wr rd clr din | chk dout level empty full af ae ovf unf
    for (int i = 1; i <= 8; i++) begin
      add(1, 0, 0, 8'(i), 1, 8'h01, 4'(i), 0, (i == 8), (i >= 6), (i <= 1), 0, 0);
    end
    add(1, 0, 0, 8'hFF, 1, 8'h01, 8, 0, 1, 1, 0, 1, 0); // dropped write
    add(1, 1, 0, 8'hAA, 1, 8'h02, 8, 0, 1, 1, 0, 1, 0);
    add(1, 1, 0, 8'hAA, 1, 8'h03, 8, 0, 1, 1, 0, 1, 0);
    add(1, 1, 0, 8'hAA, 1, 8'h04, 8, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'h05, 7, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'h06, 6, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'h07, 5, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'h08, 4, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'hAA, 3, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'hAA, 2, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 8'h00, 1, 8'hAA, 1, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 1, 1); // read while empty
    add(0, 1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0); // clear beats set
    add(1, 1, 0, 8'h55, 1, 8'h55, 1, 0, 0, 0, 1, 0, 1); // rd+wr while empty
    add(1, 1, 0, 8'h66, 1, 8'h66, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      @(posedge clock);
      #1;
      if (vecs[i].chk_dout) chk($sformatf("vec%0d.dout", i), 32'(bus.dout), 32'(vecs[i].dout));
      chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(vecs[i].level));
      chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d.full", i), 32'(bus.full), 32'(vecs[i].full));
      chk($sformatf("vec%0d.almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
      chk($sformatf("vec%0d.almost_empty", i), 32'(bus.almost_empty), 32'(vecs[i].ae));
`ifdef PCM_FIFO_ERR_EN
      chk($sformatf("vec%0d.overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d.underflow", i), 32'(bus.underflow), 32'(vecs[i].unf));
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Interleaved stream of 20 words, wrapping the pointers twice.
    wcount = 0;
    popped = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (wcount == 20 && q.size() == 0) break;
      wr_now = (wcount < 20) && (cyc % 4 != 3);
      rd_now = (cyc % 3 != 0);
      wacc   = wr_now && (q.size() < 8 || rd_now);
      racc   = rd_now && (q.size() > 0);
      drive(wr_now, rd_now, 1'b0, 8'(8'h30 + wcount));
      @(posedge clock);
      #1;
      if (racc) begin
        void'(q.pop_front());
        popped++;
      end
      if (wacc) begin
        q.push_back(8'(8'h30 + wcount));
        wcount++;
      end
      chk($sformatf("stream%0d.level", cyc), 32'(bus.level), 32'(q.size()));
      if (bus.level > 4'd8) chk($sformatf("stream%0d.level_max", cyc), 32'(bus.level), 32'd8);
      if (q.size() > 0) chk($sformatf("stream%0d.dout", cyc), 32'(bus.dout), 32'(q[0]));
    end
    chk("stream.popped", 32'(popped), 32'd20);
    chk("stream.empty", 32'(bus.empty), 32'd1);

    // Mid-stream reset with five words stored.
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
      @(posedge clock);
      #1;
    end
    drive(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("midreset.pre_level", 32'(bus.level), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("midreset");
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h77);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_reset.dout", 32'(bus.dout), 32'h77);
    chk("post_reset.level", 32'(bus.level), 32'd1);
    chk("post_reset.empty", 32'(bus.empty), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
